// File: rtl/wb_host_seq_pkg.sv
// Shared definitions for the Wishbone host sequencer: FSM encoding, register map
// and the default error word returned on an ack timeout.
package wb_host_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [31:0] BASE_ADDRESS = 32'h3000_0000;

  localparam logic [7:0] REG_NR       = 8'h00;
  localparam logic [7:0] REG_ID       = 8'h04;
  localparam logic [7:0] REG_IRQ      = 8'h08;
  localparam logic [7:0] REG_FIB_CTRL = 8'h0C;
  localparam logic [7:0] REG_CLOCK    = 8'h10;
  localparam logic [7:0] REG_FIB_VAL  = 8'h14;
  localparam logic [7:0] REG_WRITE    = 8'h18;
  localparam logic [7:0] REG_READ     = 8'h1C;
  localparam logic [7:0] REG_PANIC    = 8'h20;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hdead_dead;

endpackage

// File: rtl/wb_ack_timer.sv
// Ack-wait counter: cleared by load, advanced by en, expire flags the last
// permitted wait cycle (count == LIMIT-1).
module wb_ack_timer #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 16
) (
  input  logic wb_clk_i,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge wb_clk_i) begin
    if (reset || load) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (count == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/wb_host_seq.sv
// Single-outstanding Wishbone classic initiator: one command in, one bus cycle,
// one response out. Ack timeout is built only when WB_HOST_TIMEOUT_EN is defined.
module wb_host_seq
  import wb_host_seq_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter int          TIMEOUT_WIDTH  = 8,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic        wb_clk_i,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        busy,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  state_t      state, state_n;
  logic        cmd_ready_r, cmd_ready_n;
  logic        rsp_valid_r, rsp_valid_n;
  logic [31:0] rsp_dat_r, rsp_dat_n;
  logic        busy_r, busy_n;
  logic        cyc_r, cyc_n;
  logic        we_r, we_n;
  logic [3:0]  sel_r, sel_n;
  logic [31:0] adr_r, adr_n;
  logic [31:0] dat_r, dat_n;

`ifdef WB_HOST_TIMEOUT_EN
  logic rsp_err_r, rsp_err_n;
  logic timer_load, timer_en, timer_expire;

  wb_ack_timer #(
    .WIDTH (TIMEOUT_WIDTH),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .wb_clk_i (wb_clk_i),
    .reset    (reset),
    .load     (timer_load),
    .en       (timer_en),
    .expire   (timer_expire)
  );
`endif

  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      state       <= ST_IDLE;
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_dat_r   <= '0;
      busy_r      <= 1'b0;
      cyc_r       <= 1'b0;
      we_r        <= 1'b0;
      sel_r       <= '0;
      adr_r       <= '0;
      dat_r       <= '0;
`ifdef WB_HOST_TIMEOUT_EN
      rsp_err_r   <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      cmd_ready_r <= cmd_ready_n;
      rsp_valid_r <= rsp_valid_n;
      rsp_dat_r   <= rsp_dat_n;
      busy_r      <= busy_n;
      cyc_r       <= cyc_n;
      we_r        <= we_n;
      sel_r       <= sel_n;
      adr_r       <= adr_n;
      dat_r       <= dat_n;
`ifdef WB_HOST_TIMEOUT_EN
      rsp_err_r   <= rsp_err_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    cmd_ready_n = cmd_ready_r;
    rsp_valid_n = rsp_valid_r;
    rsp_dat_n   = rsp_dat_r;
    cyc_n       = cyc_r;
    we_n        = we_r;
    sel_n       = sel_r;
    adr_n       = adr_r;
    dat_n       = dat_r;
`ifdef WB_HOST_TIMEOUT_EN
    rsp_err_n   = rsp_err_r;
    timer_load  = 1'b0;
    timer_en    = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          we_n        = cmd_we;
          sel_n       = cmd_sel;
          adr_n       = cmd_adr;
          dat_n       = cmd_dat;
          cyc_n       = 1'b1;
          cmd_ready_n = 1'b0;
          state_n     = ST_BUS;
`ifdef WB_HOST_TIMEOUT_EN
          timer_load  = 1'b1;
`endif
        end
      end
      ST_BUS: begin
        // Ack takes priority over an expiry landing in the same cycle.
        if (wbm_ack_i) begin
          cyc_n       = 1'b0;
          rsp_dat_n   = we_r ? 32'h0 : wbm_dat_i;
          rsp_valid_n = 1'b1;
          state_n     = ST_RESP;
`ifdef WB_HOST_TIMEOUT_EN
          rsp_err_n   = 1'b0;
        end else if (timer_expire) begin
          cyc_n       = 1'b0;
          rsp_dat_n   = ERR_DATA;
          rsp_err_n   = 1'b1;
          rsp_valid_n = 1'b1;
          state_n     = ST_RESP;
        end else begin
          timer_en    = 1'b1;
`endif
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          cmd_ready_n = 1'b1;
          state_n     = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  assign cmd_ready = cmd_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_dat   = rsp_dat_r;
  assign busy      = busy_r;
  assign wbm_cyc_o = cyc_r;
  assign wbm_stb_o = cyc_r;
  assign wbm_we_o  = we_r;
  assign wbm_sel_o = sel_r;
  assign wbm_adr_o = adr_r;
  assign wbm_dat_o = dat_r;
`ifdef WB_HOST_TIMEOUT_EN
  assign rsp_err   = rsp_err_r;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_host_seq.sv
// Directed bench for wb_host_seq with a small register responder (registered ack)
// at 0x3000_00xx; addresses outside that window never ack.
module tb_wb_host_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;

  always #5 clk = ~clk;

  wb_host_seq #(
    .TIMEOUT_CYCLES (16),
    .TIMEOUT_WIDTH  (8),
    .ERR_DATA       (32'hdead_dead)
  ) dut (
    .wb_clk_i  (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_ack_i (wbm_ack_i),
    .wbm_dat_i (wbm_dat_i)
  );

  // Register responder: ID constant, WRITE stores per byte, READ returns WRITE.
  logic        ack_r, ack_force;
  logic [31:0] resp_dat, wr_reg;
  logic        hit;
  assign hit       = (wbm_adr_o[31:8] == 24'h30_0000);
  assign wbm_ack_i = ack_r | ack_force;
  assign wbm_dat_i = ack_force ? 32'h0bad_f00d : resp_dat;

  always @(posedge clk) begin
    if (reset) begin
      ack_r    <= 1'b0;
      resp_dat <= 32'h0;
    end else begin
      ack_r <= wbm_cyc_o && wbm_stb_o && !ack_r && hit;
      if (wbm_cyc_o && wbm_stb_o && !ack_r && hit) begin
        if (wbm_we_o) resp_dat <= 32'hffff_ffff;
        else if (wbm_adr_o[7:0] == 8'h04) resp_dat <= 32'h4669_626f;
        else if (wbm_adr_o[7:0] == 8'h1c) resp_dat <= wr_reg;
        else resp_dat <= 32'h0;
        if (wbm_we_o && wbm_adr_o[7:0] == 8'h18)
          for (int b = 0; b < 4; b++)
            if (wbm_sel_o[b]) wr_reg[8*b +: 8] <= wbm_dat_o[8*b +: 8];
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic present_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, output logic ok);
    int guard;
    @(negedge clk);
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    ok = cmd_ready;
    @(negedge clk);
  endtask

  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdat, output logic rerr,
                         output int ncyc, output int stb_bad);
    int   guard;
    logic ok;
    ncyc = 0; stb_bad = 0; rdat = 32'h0; rerr = 1'b0;
    present_cmd(we, adr, dat, sel, ok);
    cmd_valid = 1'b0;
    if (!ok) begin
      bound_fail("accept");
      return;
    end
    guard = 0;
    while (!rsp_valid && guard < 300) begin
      if (wbm_cyc_o) ncyc++;
      if (wbm_stb_o !== wbm_cyc_o) stb_bad++;
      @(negedge clk);
      guard++;
    end
    if (!rsp_valid) begin
      bound_fail("response");
      return;
    end
    if (wbm_stb_o !== wbm_cyc_o) stb_bad++;
    rdat = rsp_dat;
    rerr = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_after_consume", {31'b0, rsp_valid}, 32'h0);
    chk("cmd_ready_after_consume", {31'b0, cmd_ready}, 32'h1);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp_dat;
    logic        exp_err;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [31:0] rdat;
    logic        rerr, ok;
    int          ncyc, stb_bad, guard, hi;

    vecs[0] = '{1'b0, 32'h3000_0004, 32'h0,         4'hf, 32'h4669_626f, 1'b0, 2};
    vecs[1] = '{1'b1, 32'h3000_0018, 32'hcafe_f00d, 4'hf, 32'h0,         1'b0, 2};
    vecs[2] = '{1'b0, 32'h3000_001c, 32'h0,         4'hf, 32'hcafe_f00d, 1'b0, 2};
    vecs[3] = '{1'b1, 32'h3000_0018, 32'h1111_2222, 4'h3, 32'h0,         1'b0, 2};
    vecs[4] = '{1'b0, 32'h3000_001c, 32'h0,         4'hf, 32'hcafe_2222, 1'b0, 2};
    vecs[5] = '{1'b1, 32'h3000_0018, 32'ha5a5_5a5a, 4'hc, 32'h0,         1'b0, 2};
    vecs[6] = '{1'b0, 32'h3000_001c, 32'h0,         4'hf, 32'ha5a5_2222, 1'b0, 2};

    reset = 1'b1; ack_force = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_we = 1'b0; cmd_adr = 32'h0; cmd_dat = 32'h0; cmd_sel = 4'h0;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", {31'b0, cmd_ready}, 32'h1);
    chk("reset_flags", {28'b0, rsp_valid, rsp_err, busy, wbm_cyc_o}, 32'h0);
    chk("reset_bus_ctl", {26'b0, wbm_stb_o, wbm_we_o, wbm_sel_o}, 32'h0);
    chk("reset_adr", wbm_adr_o, 32'h0);
    chk("reset_wdat", wbm_dat_o, 32'h0);
    chk("reset_rsp_dat", rsp_dat, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, rdat, rerr, ncyc, stb_bad);
      chk($sformatf("vec%0d_rsp_dat", i), rdat, vecs[i].exp_dat);
      chk($sformatf("vec%0d_rsp_err", i), {31'b0, rerr}, {31'b0, vecs[i].exp_err});
      chk($sformatf("vec%0d_cyc_cycles", i), ncyc, vecs[i].exp_cyc);
      chk($sformatf("vec%0d_stb_eq_cyc", i), stb_bad, 32'h0);
    end

    // Response back-pressure with a second command waiting.
    present_cmd(1'b0, 32'h3000_0004, 32'h0, 4'hf, ok);
    if (!ok) bound_fail("bp_accept");
    cmd_we = 1'b1; cmd_adr = 32'h3000_0018; cmd_dat = 32'h1234_5678; cmd_sel = 4'hf;
    guard = 0;
    while (!rsp_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!rsp_valid) bound_fail("bp_response");
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'h1);
      chk("bp_rsp_dat", rsp_dat, 32'h4669_626f);
      chk("bp_cmd_ready", {31'b0, cmd_ready}, 32'h0);
      chk("bp_pending_not_taken", {31'b0, wbm_cyc_o}, 32'h0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_consumed", {30'b0, rsp_valid, cmd_ready}, 32'h1);
    chk("bp_no_same_cycle_accept", {31'b0, wbm_cyc_o}, 32'h0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_pending_on_bus", {30'b0, wbm_cyc_o, wbm_we_o}, 32'h3);
    chk("bp_pending_wdat", wbm_dat_o, 32'h1234_5678);
    guard = 0;
    while (!rsp_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!rsp_valid) bound_fail("bp_pending_response");
    chk("bp_pending_rsp_dat", rsp_dat, 32'h0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    run_txn(1'b0, 32'h3000_001c, 32'h0, 4'hf, rdat, rerr, ncyc, stb_bad);
    chk("bp_readback", rdat, 32'h1234_5678);

    // Reset mid-BUS against an address nobody answers, then a stray ack.
    present_cmd(1'b0, 32'h2000_0000, 32'h0, 4'hf, ok);
    cmd_valid = 1'b0;
    if (!ok) bound_fail("rst_accept");
    @(negedge clk);
    chk("rst_in_bus", {30'b0, busy, wbm_cyc_o}, 32'h3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_bus_dropped", {30'b0, wbm_cyc_o, wbm_stb_o}, 32'h0);
    chk("rst_ctl", {29'b0, rsp_valid, cmd_ready, busy}, 32'h2);
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    @(negedge clk);
    chk("late_ack_ignored", {29'b0, rsp_valid, busy, wbm_cyc_o}, 32'h0);

`ifdef WB_HOST_TIMEOUT_EN
    run_txn(1'b0, 32'h2000_0000, 32'h0, 4'hf, rdat, rerr, ncyc, stb_bad);
    chk("timeout_rsp_dat", rdat, 32'hdead_dead);
    chk("timeout_rsp_err", {31'b0, rerr}, 32'h1);
    chk("timeout_cyc_cycles", ncyc, 32'd16);
    chk("timeout_stb_eq_cyc", stb_bad, 32'h0);
`else
    present_cmd(1'b0, 32'h2000_0000, 32'h0, 4'hf, ok);
    cmd_valid = 1'b0;
    if (!ok) bound_fail("wait_accept");
    hi = 0;
    for (int k = 0; k < 100; k++) begin
      if (wbm_cyc_o && !rsp_valid && !rsp_err) hi++;
      @(negedge clk);
    end
    chk("wait_100_no_err", hi, 32'd100);
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    chk("wait_ack_valid", {30'b0, rsp_valid, rsp_err}, 32'h2);
    chk("wait_ack_dat", rsp_dat, 32'h0bad_f00d);
    chk("wait_ack_cyc_dropped", {31'b0, wbm_cyc_o}, 32'h0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
